// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - RV32I/RV64I immediate generation stage with 2-entry skid buffer
// Optional IMM_ZICSR_EN: SYSTEM CSR*I encodings produce the ZIMM immediate.
module imm_gen_stage #(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [PC_W-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      imm_type_o,
   output logic [PC_W-1:0] tgt_o,
   output logic [PC_W-1:0] pc_o,
   output logic            illegal_o
);

   localparam logic [2:0] T_I     = 3'b000;
   localparam logic [2:0] T_S     = 3'b001;
   localparam logic [2:0] T_B     = 3'b010;
   localparam logic [2:0] T_U     = 3'b011;
   localparam logic [2:0] T_J     = 3'b100;
   localparam logic [2:0] T_SHAMT = 3'b101;
   localparam logic [2:0] T_ZIMM  = 3'b110;
   localparam logic [2:0] T_NONE  = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      typ;
      logic [PC_W-1:0] tgt;
      logic [PC_W-1:0] pc;
      logic            ill;
   } entry_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [31:0]     imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
   logic [XLEN-1:0] shamt5, shamt_xlen;
   entry_t          dec;

   assign opcode  = instr_i[6:0];
   assign funct3  = instr_i[14:12];
   assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u32 = {instr_i[31:12], 12'b0};
   assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   // funct7/funct6 never leak into the shift amount.
   assign shamt5     = XLEN'(instr_i[24:20]);
   assign shamt_xlen = (XLEN == 64) ? XLEN'(instr_i[25:20]) : shamt5;

   always_comb begin
      dec     = '0;
      dec.typ = T_NONE;
      case (opcode)
         7'b0110111, 7'b0010111: begin
            dec.typ = T_U;
            dec.imm = XLEN'($signed(imm_u32));
         end
         7'b1101111: begin
            dec.typ = T_J;
            dec.imm = XLEN'($signed(imm_j32));
         end
         7'b1100111, 7'b0000011: begin
            dec.typ = T_I;
            dec.imm = XLEN'($signed(imm_i32));
         end
         7'b0010011: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.typ = T_SHAMT;
               dec.imm = shamt_xlen;
            end else begin
               dec.typ = T_I;
               dec.imm = XLEN'($signed(imm_i32));
            end
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  dec.typ = T_SHAMT;
                  dec.imm = shamt5;
               end else begin
                  dec.typ = T_I;
                  dec.imm = XLEN'($signed(imm_i32));
               end
            end else begin
               dec.ill = 1'b1;
            end
         end
         7'b0100011: begin
            dec.typ = T_S;
            dec.imm = XLEN'($signed(imm_s32));
         end
         7'b1100011: begin
            dec.typ = T_B;
            dec.imm = XLEN'($signed(imm_b32));
         end
         7'b1110011: begin
`ifdef IMM_ZICSR_EN
            if (funct3[2] && funct3[1:0] != 2'b00) begin
               dec.typ = T_ZIMM;
               dec.imm = XLEN'(instr_i[19:15]);
            end
`endif
         end
         default: dec.ill = 1'b1;
      endcase
      dec.pc  = pc_i;
      dec.tgt = pc_i + dec.imm[PC_W-1:0];
   end

   entry_t m_q, k_q;
   logic   m_valid, k_valid;
   logic   accept, pop;

   assign accept = in_valid_i & ~k_valid;
   assign pop    = m_valid & out_ready_i;

   // K only ever fills while M is stalled, so K valid implies upstream is blocked.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         m_valid   <= 1'b0;
         k_valid   <= 1'b0;
         m_q       <= '0;
         m_q.typ   <= T_NONE;
         k_q       <= '0;
         k_q.typ   <= T_NONE;
      end else if (flush_i) begin
         m_valid <= 1'b0;
         k_valid <= 1'b0;
      end else if (k_valid) begin
         if (pop) begin
            m_q     <= k_q;
            k_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!m_valid || pop) begin
            m_q     <= dec;
            m_valid <= 1'b1;
         end else begin
            k_q     <= dec;
            k_valid <= 1'b1;
         end
      end else if (pop) begin
         m_valid <= 1'b0;
      end
   end

   assign in_ready_o  = ~k_valid;
   assign out_valid_o = m_valid;
   assign imm_o       = m_q.imm;
   assign imm_type_o  = m_q.typ;
   assign tgt_o       = m_q.tgt;
   assign pc_o        = m_q.pc;
   assign illegal_o   = m_q.ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage (honours IMM_ZICSR_EN)
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] imm;
   logic [2:0]  imm_type;
   logic [31:0] tgt;
   logic [31:0] pc_out;
   logic        illegal;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] imm;
      logic [2:0]  typ;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   imm_gen_stage #(.XLEN(32), .PC_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .pc_i(pc),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .imm_o(imm), .imm_type_o(imm_type), .tgt_o(tgt),
      .pc_o(pc_out), .illegal_o(illegal)
   );

   always #5 clk = ~clk;

   // Reference decode built from shifts and masks on the whole word.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
      exp_t e;
      int s, t20, t19, t11;
      s   = ins;
      t20 = s >>> 20;
      t19 = s >>> 19;
      t11 = s >>> 11;
      e.imm = 32'h0;
      e.typ = 3'd7;
      e.ill = 1'b0;
      case (ins[6:0])
         7'b0110111, 7'b0010111: begin e.imm = ins & 32'hFFFFF000; e.typ = 3'd3; end
         7'b1101111: begin
            e.imm = (t11 & 32'hFFF00000) | (ins & 32'h000FF000) | ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
            e.typ = 3'd4;
         end
         7'b1100111, 7'b0000011: begin e.imm = t20; e.typ = 3'd0; end
         7'b0010011: begin
            if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) begin e.imm = (ins >> 20) & 32'h1F; e.typ = 3'd5; end
            else begin e.imm = t20; e.typ = 3'd0; end
         end
         7'b0100011: begin e.imm = (t20 & ~32'h1F) | ((ins >> 7) & 32'h1F); e.typ = 3'd1; end
         7'b1100011: begin
            e.imm = (t19 & 32'hFFFFF000) | ((ins << 4) & 32'h800) | ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
            e.typ = 3'd2;
         end
         7'b1110011: begin
`ifdef IMM_ZICSR_EN
            if (ins[14:12] >= 3'd5) begin e.imm = (ins >> 15) & 32'h1F; e.typ = 3'd6; end
`endif
         end
         default: e.ill = 1'b1;
      endcase
      e.pc  = p;
      e.tgt = p + e.imm;
      return e;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if ({imm, imm_type, tgt, pc_out, illegal} !== {32'h0, 3'd7, 32'h0, 32'h0, 1'b0})
         begin errors++; $display("FAIL reset_values got imm=%h type=%0d tgt=%h pc=%h ill=%b exp 0/7/0/0/0", imm, imm_type, tgt, pc_out, illegal); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      logic [31:0] v_ins [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h4030D093, 32'h00000000, 32'h3002D073};
      logic [31:0] v_pc  [6] = '{32'h0, 32'h100, 32'h40, 32'h8, 32'h20, 32'h10};
      logic [31:0] v_imm [6];
      logic [2:0]  v_typ [6];
      logic [31:0] v_tgt [6];
      logic        v_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      v_imm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h3, 32'h0, 32'h0};
      v_typ = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd7, 3'd7};
      v_tgt = '{32'hFFFFFFFF, 32'hFC, 32'h12345040, 32'hB, 32'h20, 32'h10};
`ifdef IMM_ZICSR_EN
      v_imm[5] = 32'h5; v_typ[5] = 3'd6; v_tgt[5] = 32'h15;
`endif
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; instr = v_ins[i]; pc = v_pc[i]; out_ready = 1'b1;
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got=%b exp=1", i, out_valid); end
         checks++; if (imm !== v_imm[i]) begin errors++; $display("FAIL dir%0d_imm got=%h exp=%h", i, imm, v_imm[i]); end
         checks++; if (imm_type !== v_typ[i]) begin errors++; $display("FAIL dir%0d_type got=%0d exp=%0d", i, imm_type, v_typ[i]); end
         checks++; if (tgt !== v_tgt[i]) begin errors++; $display("FAIL dir%0d_tgt got=%h exp=%h", i, tgt, v_tgt[i]); end
         checks++; if (pc_out !== v_pc[i]) begin errors++; $display("FAIL dir%0d_pc got=%h exp=%h", i, pc_out, v_pc[i]); end
         checks++; if (illegal !== v_ill[i]) begin errors++; $display("FAIL dir%0d_ill got=%b exp=%b", i, illegal, v_ill[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] got [3];
      int          cyc [3];
      int          n = 0;
      logic        c_taken = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h00100093; pc = 32'h200;
      @(posedge clk); #1 instr = 32'h00200093;
      @(posedge clk); #1 instr = 32'h00300093;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low%0d got=%b exp=0", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || imm !== 32'h1) begin errors++; $display("FAIL bp_hold%0d got v=%b imm=%h exp v=1 imm=1", k, out_valid, imm); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && n < 3; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) c_taken = 1'b1;
         if (out_valid && out_ready) begin got[n] = imm; cyc[n] = c; n++; end
         @(posedge clk); #1;
         if (c_taken) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++; if (n !== 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", n); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (got[i] !== 32'(i + 1)) begin errors++; $display("FAIL bp_order%0d got=%h exp=%h", i, got[i], i + 1); end
         end
         checks++; if (cyc[1] != cyc[0] + 1 || cyc[2] != cyc[1] + 1)
            begin errors++; $display("FAIL bp_gapless got=%0d,%0d,%0d exp consecutive", cyc[0], cyc[1], cyc[2]); end
      end
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'h00500093;
      repeat (2) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_full got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
      @(posedge clk); #1 in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got v=%b exp v=0", out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      in_valid = 1'b1; instr = 32'hFE000EE3; pc = 32'h300;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1; flush = 1'b1;
      @(posedge clk); #1 rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if ({out_valid, in_ready, imm, imm_type, tgt, pc_out, illegal} !== {1'b0, 1'b1, 32'h0, 3'd7, 32'h0, 32'h0, 1'b0})
         begin errors++; $display("FAIL reset_mid got v=%b r=%b imm=%h type=%0d tgt=%h pc=%h ill=%b exp 0/1/0/7/0/0/0", out_valid, in_ready, imm, imm_type, tgt, pc_out, illegal); end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic [6:0]  opc [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
                                 7'b0010011, 7'b0100011, 7'b1100011, 7'b0011011, 7'b1110011};
      exp_t        q [$];
      logic [31:0] r;
      int          idx;
      exp_t        h;
      for (int c = 0; c < 800; c++) begin
         r   = $urandom;
         idx = $urandom_range(0, 10);
         instr     = (idx == 10) ? r : {r[31:7], opc[idx]};
         pc        = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
         checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 2); end
         if (q.size() > 0) begin
            h = q[0];
            checks++;
            if ({imm, imm_type, tgt, pc_out, illegal} !== h)
               begin errors++; $display("FAIL rnd_data c=%0d got imm=%h t=%0d tgt=%h pc=%h ill=%b exp imm=%h t=%0d tgt=%h pc=%h ill=%b",
                                       c, imm, imm_type, tgt, pc_out, illegal, h.imm, h.typ, h.tgt, h.pc, h.ill); end
         end
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) q.push_back(model(instr, pc));
         if (flush) q.delete();
         @(posedge clk); #1;
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined, handshaked immediate-generation stage between fetch and decode/execute of the RV32I core.
- Decodes immediate format directly from the opcode, so no external imm_src is needed.
- Produces the XLEN-wide extended immediate, a format code, and a PC-relative target.
- Carries a 2-entry skid buffer, so upstream sees a registered ready and full throughput is kept under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- PC_W, 32, PC and target width; must be <= XLEN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  instruction valid.
- in_ready_o  out  1  stage can accept; registered.
- instr_i  in  32  instruction word.
- pc_i  in  PC_W  PC of instr_i.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- imm_o  out  XLEN  extended immediate.
- imm_type_o  out  3  format code: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 ZIMM, 111 NONE.
- tgt_o  out  PC_W  pc + imm_o, truncated to PC_W, wrap-around.
- pc_o  out  PC_W  forwarded PC.
- illegal_o  out  1  opcode not recognised.

Behaviour:
- Opcode map:
  - 0110111 / 0010111: U. Imm is {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111: J, sign-extended.
  - 1100111, 0000011: I, sign-extended.
  - 0010011: I, except funct3 = 001 or 101, which is SHAMT (see below).
  - 0100011: S.
  - 1100011: B, LSB = 0.
  - 0011011 (XLEN = 64 only): as 0010011, but SHAMT is 5 bits.
- SHAMT:
  - Zero-extended from instr[24:20] when XLEN = 32.
  - Zero-extended from instr[25:20] when XLEN = 64.
  - funct7 / funct6 bits are never part of imm_o.
- 1110011 (SYSTEM): type NONE, imm 0, illegal_o 0 (unless the optional feature is enabled).
- Any other opcode: type NONE, imm_o 0, tgt_o = pc, illegal_o 1.
- All signed formats sign-extend from instr[31]. No unsigned variants; SLTIU/BLTU use the same sign-extended immediate.
- Storage: main register M (drives the outputs) plus skid register K, each with a valid bit. Decode and target add are done combinationally before M/K capture.
- Latency: accept at cycle N gives out_valid_o = 1 at N+1 when M is empty or popping.
- Throughput: 1 per cycle.
- in_ready_o = !K.valid, registered.
- Accept = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i.
- Per-cycle update:
  - Pop with K valid: K moves to M.
  - Accept with M empty, or M popping and K empty: load M.
  - Accept while M is held (not popping): load K.
  - Order is strictly FIFO.
- While out_valid_o = 1 and out_ready_i = 0, all outputs hold stable.
- flush_i: next cycle M.valid = K.valid = 0 and in_ready_o = 1. Any same-cycle accept is discarded.
- rst_i has priority over flush_i. Both take effect mid-transfer without residue.
- Reset values: out_valid_o 0, in_ready_o 1, imm_o 0, imm_type_o 111, tgt_o 0, pc_o 0, illegal_o 0.

Optional Feature:
- Macro: IMM_ZICSR_EN.
- Defined: SYSTEM with funct3 in {101, 110, 111} gives type ZIMM, imm_o = zero-extended instr[19:15]. Other SYSTEM encodings stay NONE.
- Undefined: all SYSTEM encodings give NONE, imm 0, illegal 0. Type code 110 is never produced.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), pc 0x0, out_ready 1 -> next cycle: out_valid 1, imm 0xFFFFFFFF, type 000, illegal 0.
- beq x0,x0,-4 (0xFE000EE3), pc 0x100 -> imm 0xFFFFFFFC, type 010, tgt 0x000000FC.
- lui x5,0x12345 (0x123452B7) -> imm 0x12345000, type 011.
- srai x1,x1,3 (0x4030D093) -> imm 0x00000003, type 101.
- Backpressure sequence:
  - Hold out_ready 0 and push A, B, C back-to-back.
  - in_ready_o drops the cycle after B is accepted; C stalls; outputs hold A.
  - Raise out_ready -> A, B, C emerge in order, no gaps after the first.
- Flush, reset and ZICSR checks:
  - flush_i with both entries full -> next cycle out_valid 0, in_ready 1.
  - rst_i mid-stream -> reset values.
  - 0x00000000 -> illegal 1, imm 0.
  - csrrwi 0x3002D073 -> type 110, imm 5 with IMM_ZICSR_EN; type 111, imm 0 without.
